// File: rtl/psg_write_sequencer.sv
// Turns register-write commands into SN76489-style latch/data byte strobes on the PSG bus.
// Optional macro PSG_SEQ_SHADOW_EN keeps register shadows and drops redundant tone/attenuation writes.
module psg_write_sequencer #(
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_reg,
    input  logic [9:0] cmd_value,
    output logic [7:0] psg_data,
    output logic       psg_we_n,
    output logic       busy
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LATCH_WR  = 3'd1;
    localparam logic [2:0] ST_LATCH_GAP = 3'd2;
    localparam logic [2:0] ST_DATA_WR   = 3'd3;
    localparam logic [2:0] ST_DATA_GAP  = 3'd4;

    // The counter is loaded with length-1 on state entry and the state ends when it reads zero.
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES - 1);

    localparam logic [2:0] REG_NOISE = 3'b110;

    logic [2:0] state_q, state_d;
    logic [3:0] phase_cnt_q, phase_cnt_d;
    logic [7:0] psg_data_q, psg_data_d;
    logic       psg_we_n_q, psg_we_n_d;
    logic       busy_q, busy_d;
    logic       is_tone_q, is_tone_d;
    logic [7:0] data_byte_q, data_byte_d;

    logic       cmd_is_noise;
    logic       cmd_is_tone;
    logic       cmd_accept;
    logic       shadow_hit;
    logic       cmd_start;
    logic [7:0] latch_byte;
    logic       phase_done;

    assign cmd_ready    = (state_q == ST_IDLE) && !reset;
    assign cmd_accept   = cmd_valid && cmd_ready;
    assign cmd_is_noise = (cmd_reg == REG_NOISE);
    assign cmd_is_tone  = !cmd_reg[0] && !cmd_is_noise;
    assign phase_done   = (phase_cnt_q == 4'd0);

    always_comb begin
        latch_byte = {1'b1, cmd_reg, cmd_value[3:0]};
        if (cmd_is_noise) begin
            latch_byte = {1'b1, REG_NOISE, 1'b0, cmd_value[2:0]};
        end
    end

`ifdef PSG_SEQ_SHADOW_EN
    logic [9:0] shadow_q [8];
    logic [9:0] masked_value;

    function automatic logic [9:0] shadow_reset_value(input int idx);
        logic [9:0] rv;
        if (idx == 6) begin
            rv = 10'h004;
        end else if ((idx % 2) == 1) begin
            rv = 10'h00F;
        end else begin
            rv = 10'h001;
        end
        return rv;
    endfunction

    always_comb begin
        masked_value = {6'b0, cmd_value[3:0]};
        if (cmd_is_tone) begin
            masked_value = cmd_value;
        end else if (cmd_is_noise) begin
            masked_value = {7'b0, cmd_value[2:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= shadow_reset_value(i);
            end
        end else if (cmd_accept) begin
            shadow_q[cmd_reg] <= masked_value;
        end
    end

    // Noise writes restart the LFSR on the chip, so they are never considered redundant.
    assign shadow_hit = !cmd_is_noise && (shadow_q[cmd_reg] == masked_value);
`else
    assign shadow_hit = 1'b0;
`endif

    assign cmd_start = cmd_accept && !shadow_hit;

    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        psg_data_d  = psg_data_q;
        psg_we_n_d  = psg_we_n_q;
        is_tone_d   = is_tone_q;
        data_byte_d = data_byte_q;

        case (state_q)
            ST_IDLE: begin
                psg_we_n_d = 1'b1;
                if (cmd_start) begin
                    state_d     = ST_LATCH_WR;
                    phase_cnt_d = HOLD_LOAD;
                    psg_data_d  = latch_byte;
                    psg_we_n_d  = 1'b0;
                    is_tone_d   = cmd_is_tone;
                    data_byte_d = {2'b00, cmd_value[9:4]};
                end
            end
            ST_LATCH_WR: begin
                if (phase_done) begin
                    state_d     = ST_LATCH_GAP;
                    phase_cnt_d = GAP_LOAD;
                    psg_we_n_d  = 1'b1;
                end else begin
                    phase_cnt_d = phase_cnt_q - 4'd1;
                end
            end
            ST_LATCH_GAP: begin
                if (phase_done) begin
                    if (is_tone_q) begin
                        state_d     = ST_DATA_WR;
                        phase_cnt_d = HOLD_LOAD;
                        psg_data_d  = data_byte_q;
                        psg_we_n_d  = 1'b0;
                    end else begin
                        state_d     = ST_IDLE;
                        phase_cnt_d = 4'd0;
                    end
                end else begin
                    phase_cnt_d = phase_cnt_q - 4'd1;
                end
            end
            ST_DATA_WR: begin
                if (phase_done) begin
                    state_d     = ST_DATA_GAP;
                    phase_cnt_d = GAP_LOAD;
                    psg_we_n_d  = 1'b1;
                end else begin
                    phase_cnt_d = phase_cnt_q - 4'd1;
                end
            end
            ST_DATA_GAP: begin
                if (phase_done) begin
                    state_d     = ST_IDLE;
                    phase_cnt_d = 4'd0;
                end else begin
                    phase_cnt_d = phase_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                phase_cnt_d = 4'd0;
                psg_we_n_d  = 1'b1;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            phase_cnt_q <= 4'd0;
            psg_data_q  <= 8'h00;
            psg_we_n_q  <= 1'b1;
            busy_q      <= 1'b0;
            is_tone_q   <= 1'b0;
            data_byte_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            psg_data_q  <= psg_data_d;
            psg_we_n_q  <= psg_we_n_d;
            busy_q      <= busy_d;
            is_tone_q   <= is_tone_d;
            data_byte_q <= data_byte_d;
        end
    end

    assign psg_data = psg_data_q;
    assign psg_we_n = psg_we_n_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_psg_write_sequencer.sv
// Directed bench for psg_write_sequencer: a bus monitor pops expected strobed bytes from a scoreboard.
// Shadow behaviour is exercised when PSG_SEQ_SHADOW_EN is defined.
module tb_psg_write_sequencer;

    localparam int HOLD = 2;
    localparam int GAP  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_reg = 3'b000;
    logic [9:0] cmd_value = 10'h000;
    logic [7:0] psg_data;
    logic       psg_we_n;
    logic       busy;

    typedef struct {
        logic [7:0] data;
        int         width;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fails  = 0;

    psg_write_sequencer #(
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_reg  (cmd_reg),
        .cmd_value(cmd_value),
        .psg_data (psg_data),
        .psg_we_n (psg_we_n),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] data, input int width);
        wr_t w;
        w.data  = data;
        w.width = width;
        exp_q.push_back(w);
    endtask

    // Bus monitor: a write is a run of low strobe samples; checked when the strobe returns high.
    logic [7:0] pulse_byte = 8'h00;
    int         low_cnt = 0;
    bit         unstable = 1'b0;
    bit         prev_low = 1'b0;
    wr_t        mon_e;

    always @(negedge clk) begin
        if (psg_we_n === 1'b0) begin
            if (!prev_low) begin
                pulse_byte = psg_data;
                low_cnt    = 1;
                unstable   = 1'b0;
            end else begin
                low_cnt++;
                if (psg_data !== pulse_byte) unstable = 1'b1;
            end
        end else if (prev_low) begin
            $display("write byte %02h, strobe low %0d cycles", pulse_byte, low_cnt);
            check("pending_write", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("write_byte", 32'(pulse_byte), 32'(mon_e.data));
                check("strobe_width", low_cnt, mon_e.width);
                check("data_stable", 32'(unstable), 0);
            end
        end
        prev_low = (psg_we_n === 1'b0);
    end

    // Called at a falling edge with the sequencer idle; returns at the falling edge where cmd_ready rises.
    task automatic run_cmd(input logic [2:0] r, input logic [9:0] v, input bit tone,
                           input logic [7:0] lb, input logic [7:0] db, input int exp_busy);
        int n;
        check("ready_before_cmd", 32'(cmd_ready), 1);
        push_exp(lb, HOLD);
        if (tone) push_exp(db, HOLD);
        cmd_valid = 1'b1;
        cmd_reg   = r;
        cmd_value = v;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 1);
        check("we_n_after_accept", 32'(psg_we_n), 0);
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("occupancy", n, exp_busy);
        $display("cmd reg %b value %03h: ready again after %0d cycles", r, v, n);
    endtask

    initial begin
        int n;

        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("ready_in_reset", 32'(cmd_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        check("reset_we_n", 32'(psg_we_n), 1);
        check("reset_data", 32'(psg_data), 32'h00);
        check("reset_busy", 32'(busy), 0);
        check("reset_ready", 32'(cmd_ready), 1);

        run_cmd(3'b000, 10'h3FE, 1'b1, 8'h8E, 8'h3F, 8);
        run_cmd(3'b101, 10'h3F5, 1'b0, 8'hD5, 8'h00, 4);
        // Noise then attenuation back to back; upper value bits must be ignored.
        run_cmd(3'b110, 10'h005, 1'b0, 8'hE5, 8'h00, 4);
        run_cmd(3'b001, 10'h3CA, 1'b0, 8'h9A, 8'h00, 4);
        check("idle_holds_data", 32'(psg_data), 32'h9A);
        check("idle_busy", 32'(busy), 0);
        run_cmd(3'b100, 10'h2A7, 1'b1, 8'hC7, 8'h2A, 8);

        // Second command presented while busy: it must wait and be taken on the first idle cycle.
        push_exp(8'hA5, HOLD);
        push_exp(8'h15, HOLD);
        push_exp(8'hB3, HOLD);
        cmd_valid = 1'b1;
        cmd_reg   = 3'b010;
        cmd_value = 10'h155;
        @(negedge clk);
        cmd_reg   = 3'b011;
        cmd_value = 10'h003;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("held_occupancy", n, 8);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("held_accepted", 32'(psg_we_n), 0);
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("held_second_occupancy", n, 4);
        $display("held cmd reg 011 value 003: ready again after %0d cycles", n);

        // Reset on the first data-write cycle of a tone command.
        push_exp(8'h83, HOLD);
        push_exp(8'h12, 1);
        cmd_valid = 1'b1;
        cmd_reg   = 3'b000;
        cmd_value = 10'h123;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("data_wr_strobe", 32'(psg_we_n), 0);
        check("data_wr_byte", 32'(psg_data), 32'h12);
        reset = 1'b1;
        @(negedge clk);
        check("abort_we_n", 32'(psg_we_n), 1);
        check("abort_data", 32'(psg_data), 32'h00);
        check("abort_busy", 32'(busy), 0);
        check("abort_ready_in_reset", 32'(cmd_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready_after", 32'(cmd_ready), 1);
        $display("reset during data write: strobe released, ready=%0d", cmd_ready);
        repeat (6) @(negedge clk);

`ifdef PSG_SEQ_SHADOW_EN
        cmd_valid = 1'b1;
        cmd_reg   = 3'b010;
        cmd_value = 10'h001;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("shadow_ready", 32'(cmd_ready), 1);
        check("shadow_we_n", 32'(psg_we_n), 1);
        check("shadow_busy", 32'(busy), 0);
        $display("cmd reg 010 value 001: suppressed by shadow, ready=%0d", cmd_ready);
        repeat (3) @(negedge clk);
        run_cmd(3'b110, 10'h004, 1'b0, 8'hE4, 8'h00, 4);
`else
        run_cmd(3'b010, 10'h001, 1'b1, 8'hA1, 8'h00, 8);
        run_cmd(3'b110, 10'h004, 1'b0, 8'hE4, 8'h00, 4);
`endif

        repeat (10) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("final_we_n", 32'(psg_we_n), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/psg_write_sequencer.md
PSG_WRITE_SEQUENCER -- requirements
Module: psg_write_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 2, cycles psg_we_n held low per byte (legal 1..15).
REQ-002 Parameter GAP_CYCLES, default 2, cycles psg_we_n held high after each byte (legal 1..15).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  sequencer can accept a command this cycle.
REQ-007 cmd_reg  input  3  target register, PSG encoding: 000/010/100 tone0..2 frequency, 110 noise control, 001/011/101/111 attenuation ch0..3.
REQ-008 cmd_value  input  10  register value, right-aligned; unused upper bits ignored.
REQ-009 psg_data  output  8  PSG data bus byte.
REQ-010 psg_we_n  output  1  PSG write strobe, active low.
REQ-011 busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 States: IDLE, LATCH_WR, LATCH_GAP, DATA_WR, DATA_GAP; psg_data, psg_we_n, busy are registered.
REQ-013 cmd_ready = (state==IDLE); a command is accepted only on a cycle with cmd_valid && cmd_ready; cmd_reg and cmd_value are captured at acceptance.
REQ-014 cmd_valid without cmd_ready: no capture, no state change; the command must be held by the source.
REQ-015 Latch byte: tone {1,reg,value[3:0]}; attenuation {1,reg,value[3:0]}; noise {1,110,0,value[2:0]}.
REQ-016 Data byte (tone only): {2'b00,value[9:4]}.
REQ-017 Acceptance edge -> next cycle LATCH_WR: psg_data = latch byte, psg_we_n = 0 for exactly HOLD_CYCLES cycles.
REQ-018 LATCH_GAP: psg_we_n = 1 for exactly GAP_CYCLES cycles, psg_data unchanged.
REQ-019 After LATCH_GAP: tone -> DATA_WR; attenuation/noise -> IDLE.
REQ-020 DATA_WR: psg_data = data byte, psg_we_n = 0 for HOLD_CYCLES; then DATA_GAP for GAP_CYCLES with psg_we_n = 1; then IDLE.
REQ-021 Occupancy: single-byte command HOLD+GAP cycles, tone command 2*(HOLD+GAP) cycles, from first low strobe cycle to cmd_ready high.
REQ-022 A new command may be accepted on the first IDLE cycle; no extra idle cycle is inserted between back-to-back commands.
REQ-023 psg_data holds the last driven byte in IDLE; psg_data never changes while psg_we_n = 0.
REQ-024 One shared phase counter, width sufficient for 15, reloads at every state entry; no wrap-around is observable.

Reset
REQ-025 While reset is high at a clock edge: state <= IDLE, psg_data <= 8'h00, psg_we_n <= 1, busy <= 0, counter <= 0.
REQ-026 Reset mid-byte aborts the sequence; psg_we_n is high from the cycle after the reset edge; no further byte of the aborted command is emitted.
REQ-027 cmd_ready is 0 during reset and 1 on the first cycle after reset deasserts.

Configuration
REQ-028 Macro PSG_SEQ_SHADOW_EN.
REQ-029 Defined: shadow copies of all 8 registers are kept, with reset values attenuation 4'hF, tone 10'h001, noise 3'b100, updated at acceptance.
REQ-030 Defined: a tone or attenuation command whose masked value equals its shadow is accepted and retired in the acceptance cycle, with no bus activity and cmd_ready staying high.
REQ-031 Defined: noise commands are always emitted, because every noise write restarts the noise generator.
REQ-032 Not defined: no shadow storage; every accepted command is emitted per REQ-017..REQ-020.

Verification
REQ-033 Reset high 2 cycles, then release -> psg_we_n=1, psg_data=8'h00, busy=0, cmd_ready=1 on the first cycle after release.
REQ-034 Tone0: reg 000, value 10'h3FE -> 8'h8E with we_n low 2 cycles, high 2, then 8'h3F with we_n low 2 cycles, high 2; cmd_ready returns after 8 cycles.
REQ-035 Attenuation2: reg 101, value 10'h3F5 -> single byte 8'hD5, we_n low 2 cycles; cmd_ready returns after 4 cycles.
REQ-036 Noise: reg 110, value 3'b101 -> byte 8'hE5; an immediate second command is accepted on the first IDLE cycle with no extra gap.
REQ-037 Reset asserted on the 1st DATA_WR cycle of a tone command -> psg_we_n=1 and psg_data=8'h00 the next cycle; the data byte is not re-emitted after release.
REQ-038 With PSG_SEQ_SHADOW_EN: tone1 value 10'h001 after reset -> no we_n pulse and cmd_ready stays 1; noise 3'b100 after reset -> 8'hE4 emitted.
